// File: rtl/sd_port_arbiter.sv
// Purpose: shares one HPS block-device slot between SDC (client 0) and FDC (client 1), one sector at a time, round-robin.
// Latency: request to sd_rd/sd_wr/sd_lba is 1 cycle; ack, buffer strobe and buffer data paths are combinational.
// Backpressure: requests are level-held; a waiting client is served on IDLE. Build option SD_ARB_TIMEOUT_EN adds an ack watchdog.
module sd_port_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] cl_lba [2],
    input  logic [1:0]  cl_rd,
    input  logic [1:0]  cl_wr,
    output logic [1:0]  cl_ack,
    output logic [1:0]  cl_buff_wr,
    input  logic [7:0]  cl_buff_din [2],
    output logic [1:0]  cl_err,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

    state_t      state, state_nxt;
    logic        owner_nxt;
    logic        last_owner, last_owner_nxt;
    logic        sd_rd_nxt, sd_wr_nxt;
    logic [31:0] sd_lba_nxt;
    logic [1:0]  req;
    logic        grant;
    logic        active;
    logic        tmo_hit;

    assign req   = cl_rd | cl_wr;
    // On a tie the client that did not go last wins; a lone requester wins outright.
    assign grant = (req == 2'b11) ? ~last_owner : req[1];

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0] tmo_cnt;
    logic [1:0]  err_q;

    assign tmo_hit = (state == ISSUE) && !sd_ack && (tmo_cnt == TIMEOUT - 24'd1);
    assign cl_err  = err_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tmo_cnt <= 24'd0;
            err_q   <= 2'b00;
        end else begin
            err_q <= 2'b00;
            if (tmo_hit)
                err_q[owner] <= 1'b1;
            if (state == IDLE && req != 2'b00)
                tmo_cnt <= 24'd0;
            else if (state == ISSUE)
                tmo_cnt <= tmo_cnt + 24'd1;
        end
    end
`else
    logic unused_timeout;

    assign tmo_hit        = 1'b0;
    assign unused_timeout = ^TIMEOUT;
    assign cl_err         = 2'b00;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            sd_lba     <= 32'd0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            sd_lba     <= sd_lba_nxt;
            sd_rd      <= sd_rd_nxt;
            sd_wr      <= sd_wr_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        sd_lba_nxt     = sd_lba;
        sd_rd_nxt      = sd_rd;
        sd_wr_nxt      = sd_wr;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    state_nxt  = ISSUE;
                    owner_nxt  = grant;
                    sd_lba_nxt = cl_lba[grant];
                    // Write takes precedence when a client raises both.
                    sd_wr_nxt  = cl_wr[grant];
                    sd_rd_nxt  = ~cl_wr[grant];
                end
            end
            ISSUE: begin
                if (sd_ack) begin
                    state_nxt = XFER;
                    sd_rd_nxt = 1'b0;
                    sd_wr_nxt = 1'b0;
                end else if (tmo_hit) begin
                    state_nxt      = IDLE;
                    sd_rd_nxt      = 1'b0;
                    sd_wr_nxt      = 1'b0;
                    last_owner_nxt = owner;
                end
            end
            XFER: begin
                if (!sd_ack)
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt      = IDLE;
                last_owner_nxt = owner;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State gating makes ack/strobe fall together with an asynchronous reset.
    assign active        = (state == ISSUE) || (state == XFER);
    assign cl_ack[0]     = sd_ack & active & ~owner;
    assign cl_ack[1]     = sd_ack & active & owner;
    assign cl_buff_wr[0] = sd_buff_wr & sd_ack & active & ~owner;
    assign cl_buff_wr[1] = sd_buff_wr & sd_ack & active & owner;
    assign sd_buff_din   = cl_buff_din[owner];
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_sd_port_arbiter.sv
// Bench for sd_port_arbiter: scenario tasks drive clients and an HPS model, checked against a round-robin reference.
// Inputs change and outputs are sampled on the falling clock edge; the DUT registers on the rising edge.
// Build with SD_ARB_TIMEOUT_EN to exercise the watchdog with TIMEOUT=16.
module tb_sd_port_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] cl_lba [2];
    logic [1:0]  cl_rd, cl_wr;
    logic [1:0]  cl_ack, cl_buff_wr, cl_err;
    logic [7:0]  cl_buff_din [2];
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack, sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic        busy, owner;

    int vectors     = 0;
    int miscompares = 0;
    int m_last;     // reference: client served most recently

    always #5 CLK = ~CLK;

    sd_port_arbiter #(.TIMEOUT(24'd16)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .cl_lba     (cl_lba),
        .cl_rd      (cl_rd),
        .cl_wr      (cl_wr),
        .cl_ack     (cl_ack),
        .cl_buff_wr (cl_buff_wr),
        .cl_buff_din(cl_buff_din),
        .cl_err     (cl_err),
        .sd_lba     (sd_lba),
        .sd_rd      (sd_rd),
        .sd_wr      (sd_wr),
        .sd_ack     (sd_ack),
        .sd_buff_wr (sd_buff_wr),
        .sd_buff_din(sd_buff_din),
        .busy       (busy),
        .owner      (owner)
    );

    function automatic int pick(input logic [1:0] req, input int last);
        if (req == 2'b11) return 1 - last;
        if (req == 2'b10) return 1;
        return 0;
    endfunction

    // Called at the falling edge right after the grant edge; runs one full sector transaction.
    task automatic do_txn(input int c, input int delay, input int nbytes, input logic [1:0] rel);
        logic [1:0] cmask, exp_op;
        int pulses;
        cmask  = (c == 1) ? 2'b10 : 2'b01;
        exp_op = cl_wr[c] ? 2'b10 : 2'b01;
        pulses = 0;
        vectors++;
        if (busy !== 1'b1 || owner !== c[0]) begin
            miscompares++; $display("FAIL grant: busy=%b owner=%b expected busy=1 owner=%0d", busy, owner, c);
        end
        vectors++;
        if (sd_lba !== cl_lba[c]) begin
            miscompares++; $display("FAIL sd_lba: got %h expected %h", sd_lba, cl_lba[c]);
        end
        vectors++;
        if ({sd_wr, sd_rd} !== exp_op) begin
            miscompares++; $display("FAIL op_strobe: {wr,rd}=%b expected %b", {sd_wr, sd_rd}, exp_op);
        end
        for (int i = 0; i < delay; i++) begin
            @(negedge CLK);
            vectors++;
            if ({sd_wr, sd_rd} !== exp_op || cl_ack !== 2'b00) begin
                miscompares++; $display("FAIL issue_hold: {wr,rd}=%b cl_ack=%b expected %b/00", {sd_wr, sd_rd}, cl_ack, exp_op);
            end
        end
        sd_ack = 1'b1;
        #1;
        vectors++;
        if (cl_ack !== cmask) begin
            miscompares++; $display("FAIL cl_ack: got %b expected %b", cl_ack, cmask);
        end
        cl_rd = cl_rd & ~rel;
        cl_wr = cl_wr & ~rel;
        @(negedge CLK);
        vectors++;
        if ({sd_wr, sd_rd} !== 2'b00 || busy !== 1'b1) begin
            miscompares++; $display("FAIL strobe_drop: {wr,rd}=%b busy=%b expected 00/1", {sd_wr, sd_rd}, busy);
        end
        for (int i = 0; i < nbytes; i++) begin
            sd_buff_wr = 1'b1;
            #1;
            vectors++;
            if (cl_buff_wr !== cmask || sd_buff_din !== cl_buff_din[c]) begin
                miscompares++; $display("FAIL buff_route: cl_buff_wr=%b din=%h expected %b/%h", cl_buff_wr, sd_buff_din, cmask, cl_buff_din[c]);
            end
            pulses += cl_buff_wr[c] ? 1 : 0;
            @(negedge CLK);
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        #1;
        vectors++;
        if (pulses !== nbytes || cl_ack !== 2'b00 || cl_err !== 2'b00) begin
            miscompares++; $display("FAIL xfer_end: pulses=%0d cl_ack=%b cl_err=%b expected %0d/00/00", pulses, cl_ack, cl_err, nbytes);
        end
        @(negedge CLK);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL done_busy: got %b expected 1", busy);
        end
        @(negedge CLK);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        m_last = 1;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({sd_rd, sd_wr, busy, owner, cl_err, cl_ack, cl_buff_wr} !== 10'd0 || sd_lba !== 32'd0) begin
            miscompares++; $display("FAIL reset_state: rd=%b wr=%b busy=%b owner=%b err=%b lba=%h expected all 0", sd_rd, sd_wr, busy, owner, cl_err, sd_lba);
        end
        @(negedge CLK);
        RESET = 1'b0;
        m_last = 1;
    endtask

    task automatic test_single_read();
        cl_lba[0] = 32'h0000_0123;
        cl_buff_din[0] = 8'h3C;
        cl_rd = 2'b01;
        @(negedge CLK);
        do_txn(0, 5, 512, 2'b01);
        m_last = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++; $display("FAIL no_reissue: busy=%b expected 0", busy);
            end
        end
    endtask

    task automatic test_simultaneous();
        int exp;
        pulse_reset();
        cl_lba[0] = $urandom;
        cl_lba[1] = $urandom;
        cl_rd = 2'b11;
        exp = pick(2'b11, m_last);
        @(negedge CLK);
        do_txn(exp, 2, 4, (exp == 1) ? 2'b10 : 2'b01);
        m_last = exp;
        exp = pick(cl_rd | cl_wr, m_last);
        @(negedge CLK);
        do_txn(exp, 1, 3, 2'b11);
        m_last = exp;
    endtask

    task automatic test_round_robin();
        int exp;
        int order [4];
        cl_lba[0] = $urandom;
        cl_lba[1] = $urandom;
        cl_rd = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp = pick(2'b11, m_last);
            order[k] = exp;
            @(negedge CLK);
            do_txn(exp, $urandom_range(0, 3), $urandom_range(1, 5), (k == 3) ? 2'b11 : 2'b00);
            m_last = exp;
        end
        vectors++;
        if (order[0] !== 0 || order[1] !== 1 || order[2] !== 0 || order[3] !== 1) begin
            miscompares++; $display("FAIL rr_order: got %0d%0d%0d%0d expected 0101", order[0], order[1], order[2], order[3]);
        end
    endtask

    task automatic test_write_routing();
        cl_buff_din[0] = 8'h00;
        cl_buff_din[1] = 8'hA5;
        cl_lba[1] = 32'hDEAD_0042;
        cl_wr = 2'b10;
        @(negedge CLK);
        do_txn(1, 2, 8, 2'b10);
        m_last = 1;
    endtask

    task automatic test_withdraw();
        cl_lba[0] = $urandom;
        cl_rd = 2'b01;
        @(negedge CLK);
        cl_rd[1] = 1'b1;
        do_txn(0, 1, 2, 2'b11);
        m_last = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++; $display("FAIL withdrawn_issued: busy=%b expected 0", busy);
            end
        end
    endtask

    task automatic test_reset_mid_xfer();
        int exp;
        cl_lba[1] = $urandom;
        cl_wr = 2'b10;
        @(negedge CLK);
        sd_ack = 1'b1;
        @(negedge CLK);
        sd_buff_wr = 1'b1;
        #1;
        vectors++;
        if (cl_buff_wr !== 2'b10 || cl_ack !== 2'b10) begin
            miscompares++; $display("FAIL pre_reset_route: buff_wr=%b ack=%b expected 10/10", cl_buff_wr, cl_ack);
        end
        #2 RESET = 1'b1;
        #1;
        vectors++;
        if ({sd_rd, sd_wr, busy, cl_ack, cl_buff_wr} !== 7'd0) begin
            miscompares++; $display("FAIL async_reset: rd=%b wr=%b busy=%b ack=%b buff_wr=%b expected all 0", sd_rd, sd_wr, busy, cl_ack, cl_buff_wr);
        end
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
        cl_wr = 2'b00;
        @(negedge CLK);
        RESET = 1'b0;
        m_last = 1;
        cl_lba[0] = $urandom;
        cl_rd = 2'b11;
        exp = pick(2'b11, m_last);
        @(negedge CLK);
        do_txn(exp, 0, 2, 2'b11);
        m_last = exp;
    endtask

    task automatic test_random();
        int exp;
        int op;
        for (int it = 0; it < 24; it++) begin
            for (int c = 0; c < 2; c++) begin
                if (!(cl_rd[c] | cl_wr[c]) && $urandom_range(0, 1) == 1) begin
                    cl_lba[c] = $urandom;
                    cl_buff_din[c] = 8'($urandom);
                    op = $urandom_range(0, 2);
                    cl_rd[c] = (op != 1);
                    cl_wr[c] = (op != 0);
                end
            end
            if ((cl_rd | cl_wr) == 2'b00) begin
                cl_lba[it % 2] = $urandom;
                cl_rd[it % 2] = 1'b1;
            end
            exp = pick(cl_rd | cl_wr, m_last);
            @(negedge CLK);
            do_txn(exp, $urandom_range(0, 4), $urandom_range(1, 6), (exp == 1) ? 2'b10 : 2'b01);
            m_last = exp;
        end
        cl_rd = 2'b00;
        cl_wr = 2'b00;
        @(negedge CLK);
        @(negedge CLK);
    endtask

`ifdef SD_ARB_TIMEOUT_EN
    task automatic test_timeout();
        pulse_reset();
        cl_lba[0] = $urandom;
        cl_lba[1] = $urandom;
        cl_rd = 2'b11;
        @(negedge CLK);
        vectors++;
        if (owner !== 1'b0 || sd_rd !== 1'b1) begin
            miscompares++; $display("FAIL tmo_grant: owner=%b rd=%b expected 0/1", owner, sd_rd);
        end
        for (int j = 1; j < 16; j++) begin
            @(negedge CLK);
            vectors++;
            if (sd_rd !== 1'b1 || cl_err !== 2'b00) begin
                miscompares++; $display("FAIL tmo_wait: cycle %0d rd=%b err=%b expected 1/00", j, sd_rd, cl_err);
            end
        end
        @(negedge CLK);
        vectors++;
        if (sd_rd !== 1'b0 || cl_err !== 2'b01 || busy !== 1'b0) begin
            miscompares++; $display("FAIL tmo_abort: rd=%b err=%b busy=%b expected 0/01/0", sd_rd, cl_err, busy);
        end
        m_last = 0;
        @(negedge CLK);
        vectors++;
        if (cl_err !== 2'b00) begin
            miscompares++; $display("FAIL tmo_pulse_len: err=%b expected 00", cl_err);
        end
        do_txn(pick(2'b11, m_last), 1, 2, 2'b11);
        m_last = 1;
    endtask
`else
    task automatic test_no_timeout();
        cl_lba[1] = $urandom;
        cl_rd = 2'b10;
        @(negedge CLK);
        for (int j = 0; j < 40; j++) begin
            @(negedge CLK);
            vectors++;
            if (sd_rd !== 1'b1 || cl_err !== 2'b00 || busy !== 1'b1) begin
                miscompares++; $display("FAIL issue_forever: cycle %0d rd=%b err=%b busy=%b expected 1/00/1", j, sd_rd, cl_err, busy);
            end
        end
        sd_ack = 1'b1;
        cl_rd = 2'b00;
        @(negedge CLK);
        sd_ack = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL late_ack_idle: busy=%b expected 0", busy);
        end
        m_last = 1;
    endtask
`endif

    initial begin
        RESET = 1'b1;
        cl_rd = 2'b00;
        cl_wr = 2'b00;
        cl_lba[0] = 32'd0;
        cl_lba[1] = 32'd0;
        cl_buff_din[0] = 8'd0;
        cl_buff_din[1] = 8'd0;
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
        m_last = 1;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_round_robin();
        test_write_routing();
        test_withdraw();
        test_reset_mid_xfer();
        test_random();
`ifdef SD_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
